ac_run_level_scanner: RTL

- Sits between the quantiser (pre_quant_qt_qscale) and entropy_encode_ac_run_coefficients / entropy_encode_ac_level_coefficients.
- Buffers one slice of BLOCKS quantised 8x8 blocks, then scans the AC coefficients in ProRes slice order: scan index outer (1..63), block inner.
- Emits one (run, |level|, sign) tuple per nonzero coefficient over a valid/ready handshake.
- The DC coefficient (scan index 0) is skipped; it goes to the DC path.

---
 rtl/prores_scan_pkg.sv | 41 ++++
 rtl/ac_run_level_scanner_if.sv | 29 ++
 rtl/coeff_slice_buf.sv | 36 +++
 rtl/ac_run_level_scanner.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/prores_scan_pkg.sv
// Shared tables and types for the ProRes AC run/level scanner.
// SCAN_TBL maps slice scan index to raster position; SCAN_INV is its inverse.
package prores_scan_pkg;

  localparam int COEFF_W_DEF = 16;

  typedef logic signed [COEFF_W_DEF-1:0] coeff_t;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_e;

  localparam logic [5:0] SCAN_TBL [64] = '{
    6'd0,  6'd1,  6'd8,  6'd9,  6'd2,  6'd3,  6'd10, 6'd11,
    6'd16, 6'd17, 6'd24, 6'd25, 6'd18, 6'd19, 6'd26, 6'd27,
    6'd4,  6'd5,  6'd12, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14,
    6'd21, 6'd28, 6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd31,
    6'd32, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34, 6'd35, 6'd42,
    6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36, 6'd37, 6'd44,
    6'd51, 6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  localparam logic [5:0] SCAN_INV [64] = '{
    6'd0,  6'd1,  6'd4,  6'd5,  6'd16, 6'd17, 6'd21, 6'd22,
    6'd2,  6'd3,  6'd6,  6'd7,  6'd18, 6'd20, 6'd23, 6'd28,
    6'd8,  6'd9,  6'd12, 6'd13, 6'd19, 6'd24, 6'd27, 6'd29,
    6'd10, 6'd11, 6'd14, 6'd15, 6'd25, 6'd26, 6'd30, 6'd31,
    6'd32, 6'd33, 6'd37, 6'd38, 6'd45, 6'd46, 6'd53, 6'd54,
    6'd34, 6'd36, 6'd39, 6'd44, 6'd47, 6'd52, 6'd55, 6'd60,
    6'd35, 6'd40, 6'd43, 6'd48, 6'd51, 6'd56, 6'd59, 6'd61,
    6'd41, 6'd42, 6'd49, 6'd50, 6'd57, 6'd58, 6'd62, 6'd63
  };

  function automatic logic [5:0] scan_pos(input logic [5:0] idx);
    return SCAN_TBL[idx];
  endfunction

endpackage

// File: rtl/ac_run_level_scanner_if.sv
// Coefficient-in / tuple-out handshake bundle of the AC run/level scanner.
// The slave modport is the scanner side, master is the producer/consumer side.
interface ac_run_level_scanner_if #(
  parameter int COEFF_W = 16,
  parameter int RUN_W   = 8
);

  logic                      in_valid;
  logic                      in_ready;
  logic signed [COEFF_W-1:0] in_coeff;
  logic                      out_valid;
  logic                      out_ready;
  logic [RUN_W-1:0]          out_run;
  logic [COEFF_W-1:0]        out_level;
  logic                      out_sign;
  logic                      out_last;
  logic                      slice_done;

  modport master (
    output in_valid, in_coeff, out_ready,
    input  in_ready, out_valid, out_run, out_level, out_sign, out_last, slice_done
  );

  modport slave (
    input  in_valid, in_coeff, out_ready,
    output in_ready, out_valid, out_run, out_level, out_sign, out_last, slice_done
  );

endinterface

// File: rtl/coeff_slice_buf.sv
// One-slice coefficient store: one write port, one read port with a registered
// output that only updates when rd_en is high, so read data holds during stalls.
module coeff_slice_buf #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] rd_data_r;

  // Storage write port
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Registered read port
  always_ff @(posedge clock) begin
    if (rd_en) begin
      rd_data_r <= mem_r[rd_addr];
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/ac_run_level_scanner.sv
// Buffers one slice of quantised 8x8 blocks and emits (run, |level|, sign)
// tuples for the nonzero AC coefficients in ProRes slice scan order.
module ac_run_level_scanner
  import prores_scan_pkg::*;
#(
  parameter int  BLOCKS  = 4,
  parameter int  COEFF_W = 16,
  localparam int RUN_W   = $clog2(63 * BLOCKS)
) (
  input  logic                 clock,
  input  logic                 reset,
  ac_run_level_scanner_if.slave bus
);

  localparam int DEPTH  = 64 * BLOCKS;
  localparam int ADDR_W = $clog2(DEPTH);
  // One spare bit so the read key can step past the largest key without wrapping.
  localparam int KEY_W  = ADDR_W + 1;
  localparam int BLK_W  = (BLOCKS > 1) ? $clog2(BLOCKS) : 1;

  localparam logic [ADDR_W-1:0]  LAST_WR   = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0]  ADDR_ONE  = ADDR_W'(1'b1);
  localparam logic [KEY_W-1:0]   FIRST_KEY = KEY_W'(BLOCKS);
  localparam logic [KEY_W-1:0]   KEY_ONE   = KEY_W'(1'b1);
  localparam logic [BLK_W-1:0]   LAST_BLK  = BLK_W'(BLOCKS - 1);
  localparam logic [BLK_W-1:0]   BLK_ONE   = BLK_W'(1'b1);
  localparam logic [RUN_W-1:0]   RUN_ONE   = RUN_W'(1'b1);
  localparam logic [COEFF_W-1:0] ZERO_C    = {COEFF_W{1'b0}};

  // Magnitude with the most negative code clamped to the largest positive code.
  function automatic logic [COEFF_W-1:0] mag_sat(input logic [COEFF_W-1:0] c);
    logic [COEFF_W-1:0] min_v;
    min_v = {1'b1, {(COEFF_W-1){1'b0}}};
    if (c == min_v) begin
      return {1'b0, {(COEFF_W-1){1'b1}}};
    end else if (c[COEFF_W-1]) begin
      return (~c) + {{(COEFF_W-1){1'b0}}, 1'b1};
    end else begin
      return c;
    end
  endfunction

  scan_state_e        state_r;
  logic               in_ready_r;
  logic               has_nz_r;
  logic               rd_vld_r;
  logic               out_valid_r;
  logic               out_sign_r;
  logic               out_last_r;
  logic               slice_done_r;
  logic [ADDR_W-1:0]  wr_cnt_r;
  logic [KEY_W-1:0]   last_key_r;
  logic [KEY_W-1:0]   rd_key_r;
  logic [KEY_W-1:0]   proc_key_r;
  logic [5:0]         rd_i_r;
  logic [BLK_W-1:0]   rd_b_r;
  logic [RUN_W-1:0]   run_r;
  logic [RUN_W-1:0]   out_run_r;
  logic [COEFF_W-1:0] out_level_r;

  logic               wr_en_s;
  logic               fill_nz_s;
  logic [KEY_W-1:0]   fill_key_s;
  logic               out_hs_s;
  logic               consume_s;
  logic               more_s;
  logic               rd_en_s;
  logic               rd_nz_s;
  logic [ADDR_W-1:0]  rd_addr_s;
  logic [COEFF_W-1:0] rd_data_s;

  // Write/read strobes, scan key of the incoming beat and the scan read address
  always_comb begin
    out_hs_s   = out_valid_r && bus.out_ready;
    wr_en_s    = (state_r == FILL) && in_ready_r && bus.in_valid;
    fill_key_s = KEY_W'(SCAN_INV[wr_cnt_r[5:0]]) * KEY_W'(BLOCKS) + KEY_W'(wr_cnt_r >> 3'd6);
    fill_nz_s  = wr_en_s && (SCAN_INV[wr_cnt_r[5:0]] != 6'd0) && (bus.in_coeff != ZERO_C);
    more_s     = (rd_key_r <= last_key_r);
    consume_s  = (state_r == SCAN) && rd_vld_r && (!out_valid_r || out_hs_s);
    rd_en_s    = (state_r == SCAN) && has_nz_r && more_s && (!rd_vld_r || consume_s)
                 && !(out_hs_s && out_last_r);
    rd_nz_s    = (rd_data_s != ZERO_C);
    rd_addr_s  = ADDR_W'({rd_b_r, 6'd0}) + ADDR_W'(scan_pos(rd_i_r));
  end

  coeff_slice_buf #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (COEFF_W)
  ) u_buf (
    .clock   (clock),
    .wr_en   (wr_en_s),
    .wr_addr (wr_cnt_r),
    .wr_data (bus.in_coeff),
    .rd_en   (rd_en_s),
    .rd_addr (rd_addr_s),
    .rd_data (rd_data_s)
  );

  // Slice FSM: fill the buffer, scan keys in order, then pulse slice_done
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r      <= FILL;
      in_ready_r   <= 1'b0;
      has_nz_r     <= 1'b0;
      rd_vld_r     <= 1'b0;
      out_valid_r  <= 1'b0;
      out_sign_r   <= 1'b0;
      out_last_r   <= 1'b0;
      slice_done_r <= 1'b0;
      wr_cnt_r     <= {ADDR_W{1'b0}};
      last_key_r   <= {KEY_W{1'b0}};
      rd_key_r     <= {KEY_W{1'b0}};
      proc_key_r   <= {KEY_W{1'b0}};
      rd_i_r       <= 6'd0;
      rd_b_r       <= {BLK_W{1'b0}};
      run_r        <= {RUN_W{1'b0}};
      out_run_r    <= {RUN_W{1'b0}};
      out_level_r  <= {COEFF_W{1'b0}};
    end else begin
      case (state_r)
        FILL: begin
          if (wr_en_s) begin
            if (fill_nz_s) begin
              has_nz_r <= 1'b1;
              if (fill_key_s > last_key_r) begin
                last_key_r <= fill_key_s;
              end
            end
            if (wr_cnt_r == LAST_WR) begin
              wr_cnt_r   <= {ADDR_W{1'b0}};
              in_ready_r <= 1'b0;
              state_r    <= SCAN;
              rd_i_r     <= 6'd1;
              rd_b_r     <= {BLK_W{1'b0}};
              rd_key_r   <= FIRST_KEY;
              run_r      <= {RUN_W{1'b0}};
              rd_vld_r   <= 1'b0;
            end else begin
              wr_cnt_r   <= wr_cnt_r + ADDR_ONE;
              in_ready_r <= 1'b1;
            end
          end else begin
            in_ready_r <= 1'b1;
          end
        end

        SCAN: begin
          if (!has_nz_r) begin
            state_r      <= DONE;
            slice_done_r <= 1'b1;
          end else begin
            if (rd_en_s) begin
              rd_key_r   <= rd_key_r + KEY_ONE;
              proc_key_r <= rd_key_r;
              rd_vld_r   <= 1'b1;
              if (rd_b_r == LAST_BLK) begin
                rd_b_r <= {BLK_W{1'b0}};
                rd_i_r <= rd_i_r + 6'd1;
              end else begin
                rd_b_r <= rd_b_r + BLK_ONE;
              end
            end else if (consume_s) begin
              rd_vld_r <= 1'b0;
            end

            if (consume_s && rd_nz_s) begin
              out_valid_r <= 1'b1;
              out_run_r   <= run_r;
              out_level_r <= mag_sat(rd_data_s);
              out_sign_r  <= rd_data_s[COEFF_W-1];
              out_last_r  <= (proc_key_r == last_key_r);
              run_r       <= {RUN_W{1'b0}};
            end else begin
              if (out_hs_s) begin
                out_valid_r <= 1'b0;
              end
              if (consume_s) begin
                run_r <= run_r + RUN_ONE;
              end
            end

            // Nothing past the last nonzero key is ever read, so the scan ends here.
            if (out_hs_s && out_last_r) begin
              state_r      <= DONE;
              slice_done_r <= 1'b1;
              rd_vld_r     <= 1'b0;
            end
          end
        end

        DONE: begin
          slice_done_r <= 1'b0;
          has_nz_r     <= 1'b0;
          last_key_r   <= {KEY_W{1'b0}};
          in_ready_r   <= 1'b1;
          state_r      <= FILL;
        end

        default: begin
          state_r      <= FILL;
          in_ready_r   <= 1'b0;
          out_valid_r  <= 1'b0;
          slice_done_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_r;
  assign bus.out_valid  = out_valid_r;
  assign bus.out_run    = out_run_r;
  assign bus.out_level  = out_level_r;
  assign bus.out_sign   = out_sign_r;
  assign bus.out_last   = out_last_r;
  assign bus.slice_done = slice_done_r;

endmodule
